uart_tx_core: RTL and testbench

UART_TX_CORE -- requirements
Module: uart_tx_core

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_baud_tick.sv | 39 +++
 rtl/uart_tx_core.sv | 126 ++++++++++++
 tb/tb_uart_tx_core.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg: shared types and constants for the UART transmitter slice.
//   uart_state_e    : transmitter FSM states
//   UART_DATA_BITS  : data bits per frame
//   UART_IDLE_LEVEL : serial line level when idle / stop bit
//   UART_BIT_IDX_W  : width of the data-bit index
//   even_parity()   : XOR of the data bits
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam int unsigned UART_DATA_BITS  = 8;
    localparam logic        UART_IDLE_LEVEL = 1'b1;
    localparam int unsigned UART_BIT_IDX_W  = 3;

    function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] i_data);
        return ^i_data;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// ---------------------------------------------------------------------------
// uart_baud_tick: bit-period counter. Counts 0..CLKS_PER_BIT-1 while run is
// high and pulses tick for one cycle on the terminal count (the wrap).
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   run   : count enable; counter is held at 0 while low
//   tick  : one-cycle pulse on the last cycle of each bit period
// ---------------------------------------------------------------------------
module uart_baud_tick #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic tick
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_wrap;

    assign w_wrap = (r_cnt == CNT_MAX);

    // Counter restarts from 0 on wrap and whenever the transmitter is idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (!run || w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign tick = run & w_wrap;

endmodule

// File: rtl/uart_tx_core.sv
// ---------------------------------------------------------------------------
// uart_tx_core: UART transmitter, 8 data bits LSB first, 1 stop bit.
// Build option: define UART_TX_PARITY_EN to add an even-parity bit (8E1);
// without it the frame is 8N1.
//   clk      : rising-edge clock
//   reset    : synchronous active-high reset
//   tx_data  : byte to send, captured on an accepting edge
//   tx_valid : upstream offers tx_data
//   tx_ready : high only while idle (byte can be accepted)
//   tx_busy  : inverse of tx_ready
//   UART_TX  : serial output, registered, idle high
// ---------------------------------------------------------------------------
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [UART_DATA_BITS-1:0] tx_data,
    input  logic                      tx_valid,
    output logic                      tx_ready,
    output logic                      tx_busy,
    output logic                      UART_TX
);

    uart_state_e               r_state;
    uart_state_e               w_next_state;
    logic [UART_BIT_IDX_W-1:0] r_bit_idx;
    logic [UART_BIT_IDX_W-1:0] w_bit_idx_next;
    logic [UART_DATA_BITS-1:0] r_shreg;
    logic                      r_tx;
    logic                      r_ready;
    logic                      r_busy;
    logic                      w_tx_next;
    logic                      w_accept;
    logic                      w_run;
    logic                      w_tick;

    assign w_run    = (r_state != IDLE);
    assign w_accept = (r_state == IDLE) & tx_valid;

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_tick (
        .clk   (clk),
        .reset (reset),
        .run   (w_run),
        .tick  (w_tick)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE:  if (tx_valid) w_next_state = START;
            START: if (w_tick)   w_next_state = DATA;
            DATA: begin
                if (w_tick && (r_bit_idx == UART_BIT_IDX_W'(UART_DATA_BITS - 1))) begin
`ifdef UART_TX_PARITY_EN
                    w_next_state = PARITY;
`else
                    w_next_state = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (w_tick) w_next_state = STOP;
`endif
            STOP:  if (w_tick)   w_next_state = IDLE;
            default:             w_next_state = IDLE;
        endcase
    end

    // Output logic: line level for the upcoming cycle, so UART_TX comes
    // straight from a flop and changes on the same edge as the state.
    always_comb begin
        w_bit_idx_next = r_bit_idx;
        w_tx_next      = UART_IDLE_LEVEL;
        // Index wraps 7 -> 0 as the last data bit completes.
        if ((r_state == DATA) && w_tick) begin
            w_bit_idx_next = r_bit_idx + UART_BIT_IDX_W'(1);
        end
        unique case (w_next_state)
            START:   w_tx_next = 1'b0;
            DATA:    w_tx_next = r_shreg[w_bit_idx_next];
`ifdef UART_TX_PARITY_EN
            PARITY:  w_tx_next = even_parity(r_shreg);
`endif
            default: w_tx_next = UART_IDLE_LEVEL;
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bit_idx <= '0;
            r_shreg   <= '0;
            r_tx      <= UART_IDLE_LEVEL;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            r_bit_idx <= w_bit_idx_next;
            if (w_accept) begin
                r_shreg <= tx_data;
            end
            r_tx      <= w_tx_next;
            r_ready   <= (w_next_state == IDLE);
            r_busy    <= (w_next_state != IDLE);
        end
    end

    assign UART_TX  = r_tx;
    assign tx_ready = r_ready;
    assign tx_busy  = r_busy;

endmodule

// File: tb/tb_uart_tx_core.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_core: self-checking bench for uart_tx_core at CLKS_PER_BIT=4.
// Accepted bytes are queued by the driver; the line monitor pops them and
// checks every cycle of the resulting frame. Define UART_TX_PARITY_EN for
// the 8E1 build.
// ---------------------------------------------------------------------------
module tb_uart_tx_core;

    localparam int unsigned CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned NBITS = 11;
`else
    localparam int unsigned NBITS = 10;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_busy;
    logic       UART_TX;

    int         n_cmp = 0;
    int         n_err = 0;
    int         n_acc = 0;
    logic [7:0] exp_q[$];

    uart_tx_core #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_busy  (tx_busy),
        .UART_TX  (UART_TX)
    );

    always #5 clk = ~clk;

    // Handshake counter (reset has priority, so no accept while it is high).
    always @(posedge clk) begin
        if (!reset && tx_valid && tx_ready) n_acc <= n_acc + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected line levels for one frame, index 0 = start bit.
    function automatic logic [NBITS-1:0] frame_bits(input logic [7:0] b);
        logic [NBITS-1:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = b;
`ifdef UART_TX_PARITY_EN
        f[9]   = ^b;
`endif
        return f;
    endfunction

    task automatic wait_ready(input bit scramble);
        int n;
        n = 0;
        while (tx_ready !== 1'b1 && n < 200) begin
            if (scramble) tx_data = 8'($urandom);
            @(negedge clk);
            n++;
        end
        if (tx_ready !== 1'b1) check("ready_timeout", 0, 1);
    endtask

    task automatic drive_byte(input logic [7:0] b, input bit hold, input bit scramble);
        wait_ready(scramble);
        tx_data  = b;
        tx_valid = 1'b1;
        exp_q.push_back(b);
        @(negedge clk);
        if (!hold) tx_valid = 1'b0;
    endtask

    // Wait for a start bit, then check each cycle of the frame.
    task automatic mon_frame(input int max_wait, output int waited);
        logic [7:0]       b;
        logic [NBITS-1:0] bits;
        waited = 0;
        while (UART_TX !== 1'b0 && waited < max_wait) begin
            @(negedge clk);
            waited++;
        end
        if (UART_TX !== 1'b0) begin
            check("start_timeout", 0, 1);
            return;
        end
        if (exp_q.size() == 0) begin
            check("unexpected_frame", 0, 1);
            b = 8'h00;
        end else begin
            b = exp_q.pop_front();
        end
        bits = frame_bits(b);
        for (int i = 0; i < int'(NBITS); i++) begin
            for (int k = 0; k < int'(CPB); k++) begin
                check($sformatf("byte%02h_bit%0d_cyc%0d", b, i, k), 32'(UART_TX), 32'(bits[i]));
                check($sformatf("byte%02h_busy%0d", b, i), 32'({tx_ready, tx_busy}), 32'(2'b01));
                @(negedge clk);
            end
        end
        check("end_idle", 32'({UART_TX, tx_ready, tx_busy}), 32'(3'b110));
    endtask

    task automatic check_idle(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            check(tag, 32'({UART_TX, tx_ready, tx_busy}), 32'(3'b110));
        end
    endtask

    initial begin
        int w;
        int w2;
        int acc0;
        reset    = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;

        // Reset held for 10 cycles.
        @(posedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("rst_hold", 32'({UART_TX, tx_ready, tx_busy}), 32'(3'b110));
        end
        reset = 1'b0;
        check_idle("rst_after", 3);

        // Single byte 0xA5: start the cycle after acceptance.
        acc0 = n_acc;
        fork
            drive_byte(8'hA5, 1'b0, 1'b0);
            begin
                mon_frame(20, w);
                check("a5_start_latency", 32'(w), 32'd1);
            end
        join
        check("a5_accepts", 32'(n_acc - acc0), 32'd1);

        // Back-to-back with tx_valid held; data scrambled while busy.
        check_idle("pre_b2b", 2);
        acc0 = n_acc;
        fork
            begin
                drive_byte(8'h00, 1'b1, 1'b0);
                drive_byte(8'hFF, 1'b0, 1'b1);
            end
            begin
                mon_frame(20, w);
                check("b2b_latency", 32'(w), 32'd1);
                mon_frame(20, w2);
                check("b2b_idle_gap", 32'(w2), 32'd1);
            end
        join
        check("b2b_accepts", 32'(n_acc - acc0), 32'd2);

        // Valid pulse mid-frame is ignored.
        check_idle("pre_busy", 2);
        acc0 = n_acc;
        fork
            drive_byte(8'h81, 1'b0, 1'b0);
            begin
                repeat (10) @(negedge clk);
                tx_data  = 8'h3C;
                tx_valid = 1'b1;
                @(negedge clk);
                tx_valid = 1'b0;
                tx_data  = 8'h00;
            end
            mon_frame(20, w);
        join
        check_idle("busy_post_idle", 12);
        check("busy_accepts", 32'(n_acc - acc0), 32'd1);

        // Reset during data bit 3 of 0x55 aborts the frame.
        fork
            drive_byte(8'h55, 1'b0, 1'b0);
            begin
                repeat (18) @(negedge clk);
                check("pre_rst_bit3", 32'(UART_TX), 32'd0);
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                check("rst_abort", 32'({UART_TX, tx_ready, tx_busy}), 32'(3'b110));
            end
        join
        exp_q.delete();
        check_idle("post_abort_idle", 8);
        fork
            drive_byte(8'h0F, 1'b0, 1'b0);
            mon_frame(20, w);
        join

        // Reset wins over a simultaneous tx_valid.
        acc0 = n_acc;
        @(negedge clk);
        reset    = 1'b1;
        tx_valid = 1'b1;
        tx_data  = 8'hC3;
        @(negedge clk);
        reset    = 1'b0;
        tx_valid = 1'b0;
        check("rst_vs_valid", 32'({UART_TX, tx_ready, tx_busy}), 32'(3'b110));
        check_idle("rst_vs_valid_idle", 8);
        check("rst_vs_valid_accepts", 32'(n_acc - acc0), 32'd0);

        // A few random bytes.
        for (int i = 0; i < 3; i++) begin
            logic [7:0] rb;
            rb = 8'($urandom);
            fork
                drive_byte(rb, 1'b0, 1'b0);
                mon_frame(20, w);
            join
        end

`ifdef UART_TX_PARITY_EN
        // Even parity: 0x07 -> 1, 0x03 -> 0.
        fork
            drive_byte(8'h07, 1'b0, 1'b0);
            mon_frame(20, w);
        join
        fork
            drive_byte(8'h03, 1'b0, 1'b0);
            mon_frame(20, w);
        join
`endif

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
